// File: rtl/i2c_slave_target.sv
// I2C target: oversamples sclk/sda on the system clock, matches a 7-bit address, ACKs, and then
// receives bytes into rx_data or returns tx_data bytes LSB first.
module i2c_slave_target #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_in,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_hit,
   output logic       busy,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StAddr    = 3'd1,
      StAddrAck = 3'd2,
      StRx      = 3'd3,
      StRxAck   = 3'd4,
      StTx      = 3'd5,
      StTxAck   = 3'd6
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] cnt_inc;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte_in;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       read_q, read_d;
   logic       pend_q, pend_d;
   logic       sda_q, sda_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_load_q, tx_load_d;
   logic       hit_q, hit_d;
   logic       busy_q, busy_d;

   // Synchronizers idle high so reset never looks like a bus edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], sclk_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   // Qualified on current scl only, so a STOP arriving with SCL_RISE still counts as STOP.
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;

   assign byte_in = {sda_s, shift_q[7:1]};
   assign cnt_inc = cnt_q + 3'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tx_shift_d = tx_shift_q;
      read_d     = read_q;
      pend_d     = pend_q;
      sda_d      = sda_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
      hit_d      = hit_q;
      busy_d     = busy_q;

      if (start_det) begin
         state_d = StAddr;
         cnt_d   = 3'd0;
         busy_d  = 1'b1;
         hit_d   = 1'b0;
         sda_d   = 1'b1;
         pend_d  = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         busy_d  = 1'b0;
         hit_d   = 1'b0;
         sda_d   = 1'b1;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: ;
            StAddr: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_inc;
                  if (cnt_q == 3'd7) begin
                     if (byte_in[7:1] == SLAVE_ADDR) begin
                        pend_d = 1'b1;
                        read_d = byte_in[0];
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d  = 1'b0;
                  sda_d   = 1'b0;
                  state_d = StAddrAck;
                  hit_d   = 1'b1;
                  if (read_q) begin
                     tx_shift_d = tx_data;
                     tx_load_d  = 1'b1;
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (read_q) begin
                     state_d = StTx;
                     sda_d   = tx_shift_q[0];
                  end else begin
                     state_d = StRx;
                     sda_d   = 1'b1;
                  end
               end
            end
            StRx: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_inc;
                  if (cnt_q == 3'd7) begin
                     rx_data_d  = byte_in;
                     rx_valid_d = 1'b1;
                     pend_d     = 1'b1;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d  = 1'b0;
                  sda_d   = 1'b0;
                  state_d = StRxAck;
               end
            end
            StRxAck: begin
               if (scl_fall) begin
                  sda_d   = 1'b1;
                  state_d = StRx;
                  cnt_d   = 3'd0;
               end
            end
            StTx: begin
               // cnt_q is the index of the bit currently on the bus.
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     sda_d   = 1'b1;
                     state_d = StTxAck;
                     cnt_d   = 3'd0;
                  end else begin
                     cnt_d = cnt_inc;
                     sda_d = tx_shift_q[cnt_inc];
                  end
               end
            end
            StTxAck: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     pend_d = 1'b1;
                  end else begin
                     state_d = StIdle;
                     hit_d   = 1'b0;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d     = 1'b0;
                  tx_shift_d = tx_data;
                  tx_load_d  = 1'b1;
                  sda_d      = tx_data[0];
                  state_d    = StTx;
                  cnt_d      = 3'd0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         tx_shift_q <= 8'h00;
         read_q     <= 1'b0;
         pend_q     <= 1'b0;
         sda_q      <= 1'b1;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
         hit_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tx_shift_q <= tx_shift_d;
         read_q     <= read_d;
         pend_q     <= pend_d;
         sda_q      <= sda_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_load_q  <= tx_load_d;
         hit_q      <= hit_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_out  = sda_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_load  = tx_load_q;
   assign addr_hit = hit_q;
   assign busy     = busy_q;
   assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bus master task layer plus a transaction-level model of what the
// target must drive in every bit slot, checked mid-SCL-high by a single compare process.
module tb_i2c_slave_target;

   localparam int H = 8;  // clk cycles per SCL half period
   localparam logic [6:0] ADDR = 7'h55;
   localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_AACK = 3'd2, S_RX = 3'd3,
                          S_RACK = 3'd4, S_TX = 3'd5, S_TACK = 3'd6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_in;
   logic       sda_out;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_hit;
   logic       busy;
   logic [2:0] state;

   assign sda_in = m_sda & sda_out;

   i2c_slave_target #(
      .SLAVE_ADDR (ADDR),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sclk_in (m_scl),
      .sda_in  (sda_in),
      .sda_out (sda_out),
      .tx_data (tx_data),
      .tx_load (tx_load),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .addr_hit(addr_hit),
      .busy    (busy),
      .state   (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Expectations published by the master/model layer.
   logic       chk_req = 1'b0;
   logic       e_sda = 1'b1;
   logic [2:0] e_state = 3'd0;
   logic       e_hit = 1'b0;
   logic       e_busy = 1'b0;
   string      e_tag = "";
   logic [7:0] rx_q[$];
   int         tx_loads = 0;
   int         exp_tx_loads = 0;

   always @(negedge clk) begin
      if (chk_req) begin
         chk({e_tag, "_sda_out"}, {31'd0, sda_out}, {31'd0, e_sda});
         chk({e_tag, "_state"}, {29'd0, state}, {29'd0, e_state});
         chk({e_tag, "_addr_hit"}, {31'd0, addr_hit}, {31'd0, e_hit});
         chk({e_tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
      end
      if (rx_valid) begin
         if (rx_q.size() == 0) chk("rx_valid_spurious", {31'd0, rx_valid}, 32'd0);
         else chk("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
      end
      if (tx_load) tx_loads++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic probe(input logic es, input logic [2:0] est, input logic eh, input logic eb,
                        input string tag);
      e_sda   = es;
      e_state = est;
      e_hit   = eh;
      e_busy  = eb;
      e_tag   = tag;
      chk_req = 1'b1;
      tick(1);
      chk_req = 1'b0;
   endtask

   // One SCL period with the master driving mb; target outputs checked mid-high.
   task automatic bit_cycle(input logic mb, input logic es, input logic [2:0] est, input logic eh,
                            input logic eb, input string tag);
      m_sda = mb;
      tick(H);
      m_scl = 1'b1;
      tick(H / 2);
      probe(es, est, eh, eb, tag);
      tick(H / 2 - 1);
      m_scl = 1'b0;
      tick(1);
   endtask

   task automatic start_cond(input string tag);
      if (!m_scl) begin
         m_sda = 1'b1;
         tick(H);
         m_scl = 1'b1;
         tick(H);
      end
      m_sda = 1'b0;
      tick(H / 2);
      probe(1'b1, S_ADDR, 1'b0, 1'b1, tag);
      tick(H / 2 - 1);
      m_scl = 1'b0;
      tick(1);
   endtask

   task automatic stop_cond(input string tag);
      m_sda = 1'b0;
      tick(H);
      m_scl = 1'b1;
      tick(H);
      m_sda = 1'b1;
      tick(H / 2);
      probe(1'b1, S_IDLE, 1'b0, 1'b0, tag);
      tick(H / 2 - 1);
   endtask

   // Model: the target stays in ADDR for a matching address and drops to IDLE on the last bit
   // of a non-matching one.
   task automatic addr_bits(input logic [7:0] a);
      logic match;
      match = (a[7:1] == ADDR);
      for (int i = 0; i < 8; i++)
         bit_cycle(a[i], 1'b1, (i == 7 && !match) ? S_IDLE : S_ADDR, 1'b0, 1'b1, "addr_bit");
   endtask

   task automatic addr_ack(input logic [7:0] a);
      if (a[7:1] == ADDR) begin
         if (a[0]) exp_tx_loads++;
         bit_cycle(1'b1, 1'b0, S_AACK, 1'b1, 1'b1, "addr_ack");
      end else begin
         bit_cycle(1'b1, 1'b1, S_IDLE, 1'b0, 1'b1, "addr_nack");
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      rx_q.push_back(d);
      for (int i = 0; i < 8; i++) bit_cycle(d[i], 1'b1, S_RX, 1'b1, 1'b1, "rx_bit");
      bit_cycle(1'b1, 1'b0, S_RACK, 1'b1, 1'b1, "rx_ack");
   endtask

   task automatic read_byte(input logic [7:0] t, input logic mack, input logic [7:0] next);
      for (int i = 0; i < 8; i++) bit_cycle(1'b1, t[i], S_TX, 1'b1, 1'b1, "tx_bit");
      tx_data = next;
      if (!mack) begin
         exp_tx_loads++;
         bit_cycle(1'b0, 1'b1, S_TACK, 1'b1, 1'b1, "master_ack");
      end else begin
         bit_cycle(1'b1, 1'b1, S_IDLE, 1'b0, 1'b1, "master_nack");
      end
   endtask

   initial begin
      logic [7:0] v;
      // Reset values.
      tick(3);
      chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
      chk("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      tick(4);

      // Write 0x3C.
      start_cond("start_wr");
      addr_bits(8'hAA);
      addr_ack(8'hAA);
      write_byte(8'h3C);
      stop_cond("stop_wr");
      chk("wr_rx_data_literal", {24'd0, rx_data}, 32'h3C);
      chk("wr_rx_drained", rx_q.size(), 32'd0);

      // Address mismatch.
      start_cond("start_mis");
      addr_bits(8'hA8);
      addr_ack(8'hA8);
      stop_cond("stop_mis");

      // Read 0x96 (master ACK) then 0x5A (master NACK).
      tx_data = 8'h96;
      start_cond("start_rd");
      addr_bits(8'hAB);
      addr_ack(8'hAB);
      read_byte(8'h96, 1'b0, 8'h5A);
      read_byte(8'h5A, 1'b1, 8'h00);
      stop_cond("stop_rd");
      chk("rd_tx_loads", tx_loads, exp_tx_loads);
      chk("rd_tx_loads_literal", tx_loads, 32'd2);

      // Repeated START after a partial byte.
      start_cond("start_rs");
      addr_bits(8'hAA);
      addr_ack(8'hAA);
      v = 8'b0000_1101;
      for (int i = 0; i < 4; i++) bit_cycle(v[i], 1'b1, S_RX, 1'b1, 1'b1, "partial_bit");
      start_cond("restart");
      addr_bits(8'hAA);
      addr_ack(8'hAA);
      write_byte(8'h01);
      stop_cond("stop_rs");
      chk("rs_rx_data_literal", {24'd0, rx_data}, 32'h01);

      // Async reset while the address ACK is being driven.
      start_cond("start_rst");
      addr_bits(8'hAA);
      m_sda = 1'b1;
      tick(H);
      chk("pre_rst_ack_drive", {31'd0, sda_out}, 32'd0);
      rst = 1'b0;
      #1;
      chk("async_rst_sda_out", {31'd0, sda_out}, 32'd1);
      chk("async_rst_state", {29'd0, state}, 32'd0);
      chk("async_rst_addr_hit", {31'd0, addr_hit}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_rx_data", {24'd0, rx_data}, 32'd0);
      tick(2);
      rst = 1'b1;
      tick(2);
      m_scl = 1'b1;
      tick(H / 2);
      probe(1'b1, S_IDLE, 1'b0, 1'b0, "post_rst_ack_slot");
      tick(H / 2 - 1);
      m_scl = 1'b0;
      tick(1);
      v = 8'h77;
      for (int i = 0; i < 8; i++) bit_cycle(v[i], 1'b1, S_IDLE, 1'b0, 1'b0, "ignored_bit");
      bit_cycle(1'b1, 1'b1, S_IDLE, 1'b0, 1'b0, "no_ack_after_rst");
      stop_cond("stop_rst");

      // STOP arriving together with SCL rise mid-byte.
      start_cond("start_cs");
      addr_bits(8'hAA);
      addr_ack(8'hAA);
      v = 8'b0000_0101;
      for (int i = 0; i < 3; i++) bit_cycle(v[i], 1'b1, S_RX, 1'b1, 1'b1, "cs_bit");
      m_sda = 1'b0;
      tick(H);
      m_scl = 1'b1;
      m_sda = 1'b1;
      tick(H / 2);
      probe(1'b1, S_IDLE, 1'b0, 1'b0, "stop_on_rise");
      tick(H);

      // Fresh transfer after all of the above.
      start_cond("start_fin");
      addr_bits(8'hAA);
      addr_ack(8'hAA);
      write_byte(8'hC3);
      stop_cond("stop_fin");
      chk("fin_rx_data_literal", {24'd0, rx_data}, 32'hC3);
      chk("fin_rx_drained", rx_q.size(), 32'd0);
      chk("fin_tx_loads", tx_loads, exp_tx_loads);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_target.md
Name: i2c_slave_target

Overview:
- I2C target (slave) stage sitting directly downstream of the team's I2C bus master; consumes the master's sclk/sda_out and returns sda via its own sda_out, which is wired-AND'ed with the master's into the master's sda_in.
- Oversamples the bus on the system clock, detects START/STOP, matches an address byte, ACKs, then receives bytes into rx_data or transmits tx_data bytes back to the master.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit target address; address byte bits[7:1].
- SYNC_STAGES, 2, synchronizer depth on sclk_in/sda_in (legal 2..3).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- sclk_in  input  1  bus serial clock from master.
- sda_in  input  1  resolved bus data (master AND target).
- sda_out  output  1  target data drive; 1 = released, 0 = pull low.
- tx_data  input  8  byte to return on a read; sampled at load points.
- tx_load  output  1  1-cycle pulse when tx_data is sampled.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  1-cycle pulse when rx_data updates.
- addr_hit  output  1  high from address ACK until STOP/START/NACK.
- busy  output  1  high from START until STOP.
- state  output  3  current FSM state (encoding below).

Behaviour:
- Reset (rst=0, async): sda_out=1, rx_data=0, rx_valid=0, tx_load=0, addr_hit=0, busy=0, state=IDLE, bit counter=0, synchronizer flops=1.
- Inputs pass SYNC_STAGES flops; one further flop holds the previous value for edge detect. Event latency = SYNC_STAGES+1 clk after a bus transition.
- Events: SCL_RISE, SCL_FALL; START = sda falls while scl high; STOP = sda rises while scl high. START/STOP take priority over data events in the same cycle.
- Bit order LSB first, matching the master. Sample sda on SCL_RISE; change sda_out only on SCL_FALL.
- States: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6.
- START in any state: state=ADDR, counter=0, busy=1, addr_hit=0, sda_out=1 (covers repeated START).
- STOP in any state: state=IDLE, busy=0, addr_hit=0, sda_out=1.
- ADDR: shift 8 bits. On the 8th SCL_RISE compare bits[7:1] to SLAVE_ADDR. Mismatch -> IDLE; sda stays released; busy stays 1 until STOP. Match -> at next SCL_FALL drive sda_out=0, state=ADDR_ACK, addr_hit=1.
- Address bit0=1 is a read: tx_data sampled and tx_load pulsed in the same cycle ACK is driven. bit0=0 is a write.
- ADDR_ACK: at next SCL_FALL release sda. Write -> RX. Read -> TX, driving tx bit0 on this same edge.
- RX: 8 bits. On the 8th SCL_RISE rx_data updates and rx_valid pulses. At next SCL_FALL drive ACK (0), state=RX_ACK. At following SCL_FALL release and return to RX, counter=0. Unlimited bytes.
- TX: drive bit n on each SCL_FALL. After the 8th bit's SCL_FALL release sda, state=TX_ACK.
- TX_ACK: sample master ACK on SCL_RISE. 0 -> at next SCL_FALL sample tx_data, pulse tx_load, drive bit0, state=TX. 1 (NACK) -> IDLE, addr_hit=0.
- Counter is 3 bits; wraps 7->0 only at byte completion.
- sda_out never changes while synchronized scl is high except on release by STOP/START. This guarantees the target never forges a START/STOP.
- Reset mid-transfer: immediate release (sda_out=1); the target ignores the bus until the next START.

Test Plan:
- Write: START, address byte 0xAA (0x55<<1|0) LSB first, ACK, data 0x3C -> sda_out=0 during both ACK bit periods, one rx_valid pulse with rx_data=0x3C, addr_hit=1 until STOP, then state=0, busy=0.
- Mismatch: START, address byte 0xA8 -> sda_out stays 1 throughout, state returns to IDLE after 8th bit, no rx_valid, busy=1 until STOP.
- Read with master ACK, then NACK: START, address byte 0xAB, tx_data=0x96 then 0x5A -> first byte 0x96 driven LSB first, tx_load pulses twice, second byte 0x5A; NACK -> state=IDLE, sda_out=1.
- Repeated START mid-RX after 4 bits, then address byte 0xAA plus byte 0x01 -> no rx_valid for the partial byte; new transfer yields rx_data=0x01.
- Async reset: assert rst=0 while driving ACK -> sda_out=1 and all outputs at reset values within the same cycle, no clk edge required; no ACK until a fresh START.
- STOP coincident with SCL_RISE -> STOP wins: state=IDLE, no bit captured.
